// File: rtl/ff_bank_pkg.sv
// Shared mode encodings and the per-bit next-state function for the
// multimode flip-flop bank.
package ff_bank_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    typedef struct packed {
        logic q;
        logic illegal;
    } ff_next_t;

    // Pure combinational next-state; every mode/input pair has a defined result.
    function automatic ff_next_t next_q(input logic [1:0] mode,
                                        input logic       a,
                                        input logic       b,
                                        input logic       q);
        ff_next_t r;
        r.q       = q;
        r.illegal = 1'b0;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   r.q = 1'b1;
                    2'b01:   r.q = 1'b0;
                    2'b11:   r.illegal = 1'b1;
                    default: r.q = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   r.q = 1'b1;
                    2'b01:   r.q = 1'b0;
                    2'b11:   r.q = ~q;
                    default: r.q = q;
                endcase
            end
            MODE_D:  r.q = a;
            default: r.q = a ? ~q : q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multimode_ff_bank_ff_cell.sv
// Single flip-flop channel: async active-low reset, sync clear, enable,
// runtime-selected SR/JK/D/T behaviour and a registered illegal-input flag.
module ff_cell
    import ff_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sclr,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       illegal,
    output logic       illegal_next
);

    ff_next_t nxt;
    logic     q_d, q_q;
    logic     illegal_d, illegal_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt       = next_q(mode, a, b, q_q);
        q_d       = q_q;
        illegal_d = 1'b0;
        if (sclr) begin
            q_d = 1'b0;
        end else if (en) begin
            q_d       = nxt.q;
            illegal_d = nxt.illegal;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
        end
    end

    assign q            = q_q;
    assign illegal      = illegal_q;
    assign illegal_next = illegal_d;

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-channel multimode flip-flop bank with illegal-SR reporting through
// per-bit flags, a sticky error bit and a saturating event counter.
module multimode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sclr,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic [WIDTH-1:0]     illegal,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [WIDTH-1:0]     illegal_next;
    logic                 any_illegal;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic                 err_sticky_d, err_sticky_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .sclr         (sclr),
            .mode         (mode),
            .a            (a[i]),
            .b            (b[i]),
            .q            (q[i]),
            .illegal      (illegal[i]),
            .illegal_next (illegal_next[i])
        );
    end

    assign any_illegal = |illegal_next;

    // A new illegal event outranks err_clr on the same edge.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (any_illegal) begin
            err_sticky_d = 1'b1;
            if (err_clr)
                err_cnt_d = CNT_ONE;
            else if (err_cnt_q != CNT_MAX)
                err_cnt_d = err_cnt_q + CNT_ONE;
        end else if (err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign qb         = ~q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule
